// File: rtl/control_botones.sv
// control_botones: per-button short/long press classifier feeding one-entry pending
// slots, drained round-robin into a single registered event output.
module control_botones #(
    parameter int LONG_CYC = 50000000,
    parameter int N_BTN    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic                     evt_drop
);
    localparam int CW = $clog2(LONG_CYC + 1);
    localparam int IW = $clog2(N_BTN);
    localparam logic [CW-1:0] LONG_C = CW'(LONG_CYC);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD_LONG} state_t;

    logic [N_BTN-1:0] ev, ev_long, slot_v, slot_l, slot_v_nx, slot_l_nx, grant, drop;
    logic [IW-1:0] ptr, win;
    logic any, load;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t st, st_nx;
        logic [CW-1:0] cnt, cnt_nx, inc;
        logic e, el;
        assign inc = cnt + 1'b1;
        assign ev[g] = e;
        assign ev_long[g] = el;
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                st  <= st_nx;
                cnt <= cnt_nx;
            end
        // The counter saturates at LONG_CYC because HELD_LONG never increments it.
        always_comb begin
            st_nx  = st;
            cnt_nx = cnt;
            e      = 1'b0;
            el     = 1'b0;
            case (st)
                IDLE: if (btn[g]) begin
                    st_nx  = PRESSED;
                    cnt_nx = CW'(1);
                end
                PRESSED: if (!btn[g]) begin
                    e      = 1'b1;
                    st_nx  = IDLE;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = inc;
                    if (inc == LONG_C) begin
                        e     = 1'b1;
                        el    = 1'b1;
                        st_nx = HELD_LONG;
                    end
                end
                HELD_LONG: if (!btn[g]) begin
                    st_nx  = IDLE;
                    cnt_nx = '0;
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    // Scan downward so the lowest offset from ptr is the last (winning) hit.
    always_comb begin
        win = ptr;
        any = 1'b0;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (slot_v[ptr + IW'(k)]) begin
                win = ptr + IW'(k);
                any = 1'b1;
            end
    end

    assign load  = !evt_valid || evt_ready;
    assign grant = (load && any) ? N_BTN'(1) << win : '0;

    always_comb begin
        slot_v_nx = slot_v & ~grant;
        slot_l_nx = slot_l;
        drop      = '0;
        for (int i = 0; i < N_BTN; i++)
            if (ev[i]) begin
                if (slot_v_nx[i]) drop[i] = 1'b1;
                else begin
                    slot_v_nx[i] = 1'b1;
                    slot_l_nx[i] = ev_long[i];
                end
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            slot_v    <= '0;
            slot_l    <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
            evt_drop  <= 1'b0;
        end else begin
            slot_v   <= slot_v_nx;
            slot_l   <= slot_l_nx;
            evt_drop <= |drop;
            if (load) begin
                evt_valid <= any;
                if (any) begin
                    evt_id   <= win;
                    evt_long <= slot_l[win];
                    ptr      <= win + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_control_botones.sv
// tb_control_botones: directed vector table plus hand sequences for long press,
// back-pressure/drop and reset-mid-press behaviour, with LONG_CYC=8.
module tb_control_botones;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       evt_ready = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       evt_valid, evt_long, evt_drop;
    logic [1:0] evt_id;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] b;
        logic       r;
        logic       v;
        logic [1:0] id;
        logic       l;
        logic       d;
    } vec_t;
    vec_t tbl[$];

    control_botones #(.LONG_CYC(8), .N_BTN(4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_long(evt_long), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] b, input logic v, input logic [1:0] id, input logic l);
        vec_t t;
        t.b = b; t.r = 1'b1; t.v = v; t.id = id; t.l = l; t.d = 1'b0;
        tbl.push_back(t);
    endtask

    initial begin
        // REQ-034 pair twice, right after reset so the pointer starts at 0
        for (int p = 0; p < 2; p++) begin
            add(4'b1001, 0, 0, 0); add(4'b1001, 0, 0, 0); add(4'b0000, 0, 0, 0);
            add(4'b0000, 1, 0, 0); add(4'b0000, 1, 3, 0); add(4'b0000, 0, 0, 0);
        end
        // btn[2] three samples -> short
        for (int i = 0; i < 3; i++) add(4'b0100, 0, 0, 0);
        add(4'b0000, 0, 0, 0); add(4'b0000, 1, 2, 0); add(4'b0000, 0, 0, 0);
        // btn[1] seven samples -> short
        for (int i = 0; i < 7; i++) add(4'b0010, 0, 0, 0);
        add(4'b0000, 0, 0, 0); add(4'b0000, 1, 1, 0); add(4'b0000, 0, 0, 0);
        // btn[1] eight samples -> long at the 8th sample, nothing on release
        for (int i = 0; i < 8; i++) add(4'b0010, 0, 0, 0);
        add(4'b0000, 1, 1, 1); add(4'b0000, 0, 0, 0);
        // all four at once, pointer now at 2
        add(4'b1111, 0, 0, 0); add(4'b1111, 0, 0, 0); add(4'b0000, 0, 0, 0);
        add(4'b0000, 1, 2, 0); add(4'b0000, 1, 3, 0); add(4'b0000, 1, 0, 0);
        add(4'b0000, 1, 1, 0); add(4'b0000, 0, 0, 0);

        #1;
        chk("reset valid", 32'(evt_valid), 0);
        chk("reset id", 32'(evt_id), 0);
        chk("reset long", 32'(evt_long), 0);
        chk("reset drop", 32'(evt_drop), 0);
        tick; tick;
        rst = 1'b1;
        tick;

        foreach (tbl[i]) begin
            btn = tbl[i].b;
            evt_ready = tbl[i].r;
            tick;
            chk($sformatf("row%0d valid", i), 32'(evt_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("row%0d id", i), 32'(evt_id), 32'(tbl[i].id));
                chk($sformatf("row%0d long", i), 32'(evt_long), 32'(tbl[i].l));
            end
            chk($sformatf("row%0d drop", i), 32'(evt_drop), 32'(tbl[i].d));
        end

        // btn[1] held 20 cycles: one long event after the 8th sample only
        for (int i = 1; i <= 23; i++) begin
            btn = (i <= 20) ? 4'b0010 : 4'b0000;
            tick;
            chk($sformatf("hold20 c%0d valid", i), 32'(evt_valid), 32'(i == 9));
            if (i == 9) begin
                chk("hold20 id", 32'(evt_id), 1);
                chk("hold20 long", 32'(evt_long), 1);
            end
        end

        // back-pressure: first held at output, second stored, third dropped
        evt_ready = 1'b0;
        btn = 4'b0100; tick; tick;
        btn = 4'b0000; tick;
        chk("bp first slot only", 32'(evt_valid), 0);
        tick;
        chk("bp first valid", 32'(evt_valid), 1);
        chk("bp first id", 32'(evt_id), 2);
        chk("bp first long", 32'(evt_long), 0);
        btn = 4'b0100; tick; tick;
        btn = 4'b0000; tick;
        chk("bp second drop", 32'(evt_drop), 0);
        chk("bp stable valid", 32'(evt_valid), 1);
        chk("bp stable id", 32'(evt_id), 2);
        btn = 4'b0100; tick; tick;
        chk("bp pre-third drop", 32'(evt_drop), 0);
        btn = 4'b0000; tick;
        chk("bp third drop", 32'(evt_drop), 1);
        tick;
        chk("bp drop one cycle", 32'(evt_drop), 0);
        chk("bp still valid", 32'(evt_valid), 1);
        chk("bp still id", 32'(evt_id), 2);
        evt_ready = 1'b1;
        tick;
        chk("bp second valid", 32'(evt_valid), 1);
        chk("bp second id", 32'(evt_id), 2);
        chk("bp second long", 32'(evt_long), 0);
        tick;
        chk("bp drained", 32'(evt_valid), 0);

        // reset mid-press with an event pending at the output
        evt_ready = 1'b0;
        btn = 4'b1000; tick; tick;
        btn = 4'b0000; tick; tick;
        chk("rst pending valid", 32'(evt_valid), 1);
        chk("rst pending id", 32'(evt_id), 3);
        btn = 4'b0001;
        for (int i = 0; i < 5; i++) tick;
        #2 rst = 1'b0;
        #1;
        chk("rst async valid", 32'(evt_valid), 0);
        chk("rst async id", 32'(evt_id), 0);
        chk("rst async long", 32'(evt_long), 0);
        chk("rst async drop", 32'(evt_drop), 0);
        tick; tick;
        rst = 1'b1;
        evt_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            btn = (i <= 8) ? 4'b0001 : 4'b0000;
            tick;
            chk($sformatf("rst rel c%0d valid", i), 32'(evt_valid), 32'(i == 9));
            if (i == 9) begin
                chk("rst rel id", 32'(evt_id), 0);
                chk("rst rel long", 32'(evt_long), 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/control_botones.md
CONTROL_BOTONES -- requirements
Module: control_botones

Interface
REQ-001 Parameter LONG_CYC, default 50000000, consecutive pressed cycles that qualify a long press (1 s at 50 MHz); legal range 2..2^26.
REQ-002 Parameter N_BTN, default 4, number of button channels; fixed at 4 in this revision.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  debounced button levels from the debouncer outputs, 1 = pressed, synchronous to clk.
REQ-006 evt_valid  output  1  event available on evt_id/evt_long.
REQ-007 evt_ready  input  1  consumer accepts the event when evt_valid=1 and evt_ready=1 on the same edge.
REQ-008 evt_id  output  2  index of the button that produced the event.
REQ-009 evt_long  output  1  event type: 1 = long press, 0 = short press.
REQ-010 evt_drop  output  1  one-cycle pulse when a detected event is discarded because its pending slot is full.

Function
REQ-011 Each channel SHALL run its own FSM with states IDLE, PRESSED and HELD_LONG, plus a press counter that saturates at LONG_CYC.
REQ-012 IDLE: when btn[i]=1 is sampled, the channel SHALL move to PRESSED with count=1.
REQ-013 PRESSED, btn[i]=1: the count SHALL increment by 1 each cycle; on the sample where the count reaches LONG_CYC, the channel SHALL raise a long event and move to HELD_LONG.
REQ-014 PRESSED, btn[i]=0: the channel SHALL raise a short event and return to IDLE; a short event therefore covers 1..LONG_CYC-1 pressed samples.
REQ-015 HELD_LONG: no event SHALL be raised; btn[i]=0 SHALL return the channel to IDLE, and a release after a long press SHALL produce nothing.
REQ-016 Each channel SHALL have a one-entry pending slot (valid bit + type bit), written on the same edge on which its event is detected.
REQ-017 If an event is detected while the slot is valid and the slot is not being drained on that edge, the new event SHALL be discarded, the slot SHALL keep its old content, and evt_drop SHALL be 1 for exactly the next cycle.
REQ-018 If a slot is drained and refilled on the same edge, the new event SHALL be stored and evt_drop SHALL stay 0.
REQ-019 The output stage SHALL be a single register holding evt_valid, evt_id and evt_long.
REQ-020 When evt_valid=0, or when evt_valid=1 and evt_ready=1, the output stage SHALL load the round-robin winner among valid slots and clear that slot on the same edge.
REQ-021 Arbitration SHALL be round-robin: the search starts at (last granted id + 1) mod 4; after reset the search starts at id 0.
REQ-022 While evt_valid=1 and evt_ready=0, evt_id and evt_long SHALL remain stable.
REQ-023 Latency from the edge that sets a slot to evt_valid=1 (with the output stage free) SHALL be exactly 1 cycle.
REQ-024 With every slot empty and the output stage consumed or empty, evt_valid SHALL drop to 0 at the next edge.
REQ-025 With evt_ready held at 1, back-to-back events SHALL be delivered at 1 per cycle.
REQ-026 Simultaneous events on several channels SHALL all be stored in their own slots with no loss.

Reset
REQ-027 rst=0 SHALL immediately force every FSM to IDLE and clear all counters and pending slots.
REQ-028 rst=0 SHALL immediately force evt_valid=0, evt_id=0, evt_long=0, evt_drop=0 and the round-robin pointer to 0.
REQ-029 A button held through reset release SHALL be treated as a new press starting from the first sampled cycle after release.
REQ-030 Reset asserted mid-press SHALL discard that press; no event SHALL be produced for it.

Verification (LONG_CYC=8, evt_ready=1 unless stated)
REQ-031 btn[2] high for 3 cycles then low -> one event, evt_id=2, evt_long=0; evt_valid high 1 cycle after the release-sampling edge.
REQ-032 btn[1] high for 20 cycles -> exactly one event (id=1, long=1) one cycle after the 8th high sample; no event on release.
REQ-033 btn[1] high for exactly 7 cycles -> short event; btn[1] high for exactly 8 cycles -> long event.
REQ-034 btn[0] and btn[3] short presses released on the same cycle -> events id=0 then id=3 on consecutive cycles; a repeat of the same pair -> id=0 then id=3 again, since the pointer starts after 3.
REQ-035 evt_ready=0 with a short event latched on btn[2] -> evt_valid held and outputs stable; a second and then a third short press on btn[2] -> second stored, third causes one evt_drop pulse; evt_ready=1 -> events delivered in order, first then second.
REQ-036 rst asserted while btn[0] has been held for 5 cycles and an event is pending -> outputs 0 immediately; after release with btn[0] still held for 8 cycles -> one long event only.
